// File: rtl/cart_bus_master.sv
// rtl/cart_bus_master.sv - Game Boy cartridge bus initiator: req/ack memory requests to timed setup/strobe/hold cycles.
module cart_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [14:0] cart_addr,
  output logic        cart_a15,
  output logic        nCS,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [7:0]  cart_di,
  input  logic [7:0]  cart_do,
  input  logic        cart_oe
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        cart_q, cart_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  di_q, di_d;
  logic        ncs_q, ncs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic req_cart, req_ncs, last;

  // External RAM / echo space is selected through nCS; 0x8000-0x9FFF and 0xFE00+ never reach the cart.
  assign req_ncs  = (req_addr >= 16'hA000) && (req_addr <= 16'hFDFF);
  assign req_cart = (req_addr < 16'h8000) || req_ncs;
  assign last     = (cnt_q == 4'd0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      cart_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 8'hFF;
      addr_q  <= 16'h0000;
      di_q    <= 8'hFF;
      ncs_q   <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      cart_q  <= cart_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      ncs_q   <= ncs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    cart_d  = cart_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    di_d    = di_q;
    ncs_d   = ncs_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            addr_d  = req_addr;
            we_d    = req_we;
            cart_d  = req_cart;
            busy_d  = 1'b1;
            ncs_d   = ~req_ncs;
            rd_d    = req_cart & ~req_we;
            if (req_we) di_d = req_wdata;
          end
        end
        SETUP: begin
          if (last) begin
            state_d = STROBE;
            cnt_d   = STROBE_LD;
            wr_d    = cart_q & we_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (last) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
            wr_d    = 1'b0;
            // Data is taken on the last strobe cycle, just before the strobe ends.
            if (!we_q) rdata_d = (cart_oe && cart_q) ? cart_do : 8'hFF;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (last) begin
            state_d = IDLE;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            rd_d    = 1'b0;
            ncs_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign cart_addr = addr_q[14:0];
  assign cart_a15  = addr_q[15];
  assign nCS       = ncs_q;
  assign cart_rd   = rd_q;
  assign cart_wr   = wr_q;
  assign cart_di   = di_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// tb/tb_cart_bus_master.sv - Self-checking bench for cart_bus_master against a phase-index transaction model.
module tb_cart_bus_master;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;

  logic        clk_sys = 1'b0;
  logic        reset, ce, req, req_we, cart_oe;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, cart_do;
  logic        busy, ack, cart_a15, nCS, cart_rd, cart_wr;
  logic [7:0]  rdata, cart_di;
  logic [14:0] cart_addr;

  int n_vec = 0;
  int n_err = 0;

  // Reference: an active transaction is tracked by the count of ce-qualified edges since acceptance.
  bit          m_active, m_we, m_cart, m_ncs, m_ack;
  int          m_p;
  logic [15:0] m_addr;
  logic [7:0]  m_di, m_rdata;

  cart_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .ack(ack), .rdata(rdata),
    .cart_addr(cart_addr), .cart_a15(cart_a15), .nCS(nCS), .cart_rd(cart_rd),
    .cart_wr(cart_wr), .cart_di(cart_di), .cart_do(cart_do), .cart_oe(cart_oe)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic bit in_ncs(input logic [15:0] a);
    return (a >= 16'hA000) && (a <= 16'hFDFF);
  endfunction

  function automatic bit in_cart(input logic [15:0] a);
    return (a < 16'h8000) || in_ncs(a);
  endfunction

  task automatic model_reset();
    m_active = 0; m_we = 0; m_cart = 0; m_ncs = 0; m_ack = 0; m_p = 0;
    m_addr = 16'h0000; m_di = 8'hFF; m_rdata = 8'hFF;
  endtask

  task automatic model_step(input logic c, input logic r, input logic w, input logic [15:0] a,
                            input logic [7:0] wd, input logic [7:0] cdo, input logic coe);
    m_ack = 0;
    if (c) begin
      if (!m_active) begin
        if (r) begin
          m_active = 1; m_p = 0; m_we = w; m_addr = a;
          m_cart = in_cart(a); m_ncs = in_ncs(a);
          if (w) m_di = wd;
        end
      end else begin
        if (m_p == S + T - 1 && !m_we) m_rdata = (coe && m_cart) ? cdo : 8'hFF;
        m_p++;
        if (m_p == S + T + H) begin
          m_active = 0; m_ack = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [36:0] obs, exp;
    obs = {busy, ack, rdata, cart_a15, cart_addr, nCS, cart_rd, cart_wr, cart_di};
    exp = {m_active, m_ack, m_rdata, m_addr[15], m_addr[14:0], !(m_active && m_ncs),
           m_active && m_cart && !m_we,
           m_active && m_cart && m_we && (m_p >= S) && (m_p < S + T), m_di};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic r, input logic w, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] cdo, input logic coe, input string tag);
    ce = c; req = r; req_we = w; req_addr = a; req_wdata = wd; cart_do = cdo; cart_oe = coe;
    model_step(c, r, w, a, wd, cdo, coe);
    @(negedge clk_sys);
    check_outputs(tag);
  endtask

  task automatic txn(input string tag, input logic w, input logic [15:0] a, input logic [7:0] wd,
                     input logic [7:0] cdo, input logic coe, input int off_at, input int off_len,
                     input bit keep_req, input int exp_lat, input int exp_rd, input int exp_wr);
    int  nrd, nwr;
    bit  got;
    logic c;
    nrd = 0; nwr = 0; got = 0;
    cyc(1'b1, 1'b1, w, a, wd, cdo, coe, tag);
    nrd += int'(cart_rd); nwr += int'(cart_wr);
    for (int k = 1; k <= 40 && !got; k++) begin
      c = !(k >= off_at && k < off_at + off_len);
      cyc(c, keep_req, w, a, wd, cdo, coe, tag);
      nrd += int'(cart_rd); nwr += int'(cart_wr);
      if (ack === 1'b1) begin
        got = 1;
        check_val({tag, "_ack_latency"}, k, exp_lat);
      end
    end
    if (!got) check_val({tag, "_ack_timeout"}, 0, 1);
    check_val({tag, "_rd_cycles"}, nrd, exp_rd);
    check_val({tag, "_wr_cycles"}, nwr, exp_wr);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_wdata = 8'h0; cart_do = 8'h0; cart_oe = 1'b0;
    model_reset();
    @(negedge clk_sys);
    @(negedge clk_sys);
    check_outputs("reset_state");
    reset = 1'b0;

    txn("rd_0150", 1'b0, 16'h0150, 8'h00, 8'h3E, 1'b1, 0, 0, 1'b0, 4, 4, 0);
    check_val("rd_0150_rdata", int'(rdata), 8'h3E);

    txn("wr_2000", 1'b1, 16'h2000, 8'h05, 8'hC3, 1'b1, 0, 0, 1'b0, 4, 0, 2);
    check_val("wr_2000_rdata_kept", int'(rdata), 8'h3E);

    txn("rd_A123", 1'b0, 16'hA123, 8'h00, 8'h44, 1'b0, 0, 0, 1'b0, 4, 4, 0);
    check_val("rd_A123_rdata", int'(rdata), 8'hFF);

    txn("wr_C000_ce", 1'b1, 16'hC000, 8'h77, 8'h00, 1'b0, 3, 3, 1'b0, 7, 0, 5);

    cyc(1'b1, 1'b1, 1'b1, 16'hA000, 8'h9C, 8'h00, 1'b0, "wr_A000_accept");
    cyc(1'b1, 1'b0, 1'b1, 16'hA000, 8'h9C, 8'h00, 1'b0, "wr_A000_strobe");
    check_val("wr_A000_in_strobe", int'(cart_wr), 1);
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    check_val("async_reset_wr", int'(cart_wr), 0);
    check_val("async_reset_ncs", int'(nCS), 1);
    @(negedge clk_sys);
    check_outputs("reset_hold");
    reset = 1'b0;
    txn("rd_after_reset", 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b1, 0, 0, 1'b0, 4, 4, 0);
    check_val("rd_after_reset_rdata", int'(rdata), 8'h5A);

    txn("rd_8000_b2b", 1'b0, 16'h8000, 8'h00, 8'h12, 1'b1, 0, 0, 1'b1, 4, 0, 0);
    check_val("rd_8000_rdata", int'(rdata), 8'hFF);
    txn("wr_FF80_b2b", 1'b1, 16'hFF80, 8'h99, 8'h12, 1'b1, 0, 0, 1'b1, 4, 0, 0);
    check_val("wr_FF80_rdata_kept", int'(rdata), 8'hFF);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'hFDFF + 16'($urandom_range(0, 2));
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 1'($urandom), a,
          8'($urandom), 8'($urandom), 1'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cart_bus_master.md
Name: cart_bus_master

Overview:
- Initiator side of the Game Boy cartridge bus. Its outputs drive the mapper's cart_addr, cart_a15, nCS, cart_rd, cart_wr and cart_di inputs.
- Converts single-beat CPU/DMA memory requests (req/ack handshake) into timed cartridge bus cycles: address setup, strobe, then hold.
- Captures read data returned by the mapper and reports completion.

Parameters:
SETUP_CYCLES, 1, ce-qualified cycles of address/nCS setup before strobe; legal range 1..15.
STROBE_CYCLES, 2, ce-qualified cycles the rd/wr strobe is held; legal range 1..15.
HOLD_CYCLES, 1, ce-qualified cycles of address/data hold after strobe; legal range 1..15.

Ports:
clk_sys  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
ce  in  1  phase-counter advance enable (CPU clock enable).
req  in  1  request; sampled only in IDLE; requester holds it until ack.
req_we  in  1  1 = write, 0 = read.
req_addr  in  16  CPU address.
req_wdata  in  8  write data.
busy  out  1  high from the accepting edge until ack.
ack  out  1  one-cycle completion pulse.
rdata  out  8  read result; valid with ack; held until the next ack.
cart_addr  out  15  cartridge A14..A0.
cart_a15  out  1  cartridge A15.
nCS  out  1  active-low chip select for the external-RAM region.
cart_rd  out  1  read strobe, active high.
cart_wr  out  1  write strobe, active high.
cart_di  out  8  data driven toward the cartridge.
cart_do  in  8  read data from the mapper.
cart_oe  in  1  mapper is driving valid read data.

Behaviour:
- Reset values: busy=0, ack=0, rdata=8'hFF, cart_addr=0, cart_a15=0, nCS=1, cart_rd=0, cart_wr=0, cart_di=8'hFF, state=IDLE, counter=0.
- Reset is asynchronous. Asserting it mid-cycle forces the idle values immediately and the in-flight request is dropped with no ack.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE, req=1: on that edge, latch addr, we and wdata. Drive cart_addr=req_addr[14:0] and cart_a15=req_addr[15]; for writes also drive cart_di=req_wdata. Set busy=1, load counter=SETUP_CYCLES-1, go to SETUP.
- Region classification, made at accept time:
  - cart region: 0x0000-0x7FFF and 0xA000-0xFDFF.
  - nCS region: 0xA000-0xFDFF.
  - all other addresses (0x8000-0x9FFF, 0xFE00-0xFFFF) are non-cart.
- nCS=0 from SETUP through HOLD for nCS-region requests; otherwise nCS=1.
- cart_rd=1 from SETUP through HOLD for cart-region reads.
- cart_wr=1 only in STROBE, for cart-region writes.
- Non-cart requests run the same state sequence and latency, but no strobe and no nCS assert; the read result is 8'hFF.
- Counter behaviour:
  - Decrements only on cycles with ce=1.
  - On a ce cycle with counter=0, advance SETUP->STROBE (load STROBE_CYCLES-1), STROBE->HOLD (load HOLD_CYCLES-1), or HOLD->IDLE.
  - ce=0 freezes the state and every output.
- Read capture: on the final ce cycle of STROBE, load rdata from cart_do if (cart_oe and cart region), else 8'hFF. rdata is unchanged for writes.
- HOLD->IDLE edge: ack=1 for exactly one cycle; busy=0 on the same edge. cart_rd=0 and nCS=1 when IDLE.
- cart_addr, cart_a15 and cart_di keep their last values in IDLE.
- Latency with ce held high: ack rises SETUP+STROBE+HOLD edges after the accepting edge (4 with defaults).
- A new request may be accepted on the cycle ack is high (back-to-back), giving a minimum period of S+T+H+1 cycles.
- req is ignored whenever state is not IDLE. Changes to req_* inputs after acceptance have no effect.

Test Plan:
- Read 0x0150 with cart_oe=1, cart_do=0x3E, ce=1 -> cart_addr=0x0150, a15=0, nCS=1, cart_rd high for 4 cycles, cart_wr=0; ack at edge 4; rdata=0x3E.
- Write 0x2000 with data 0x05 -> cart_di=0x05, cart_wr high exactly 2 cycles (STROBE only), cart_rd=0, nCS=1; ack at edge 4; rdata unchanged.
- Read 0xA123 with cart_oe=0 -> cart_addr=0x2123, a15=1, nCS=0 for 4 cycles; rdata=0xFF.
- Write 0xC000 with data 0x77, ce low for 3 cycles mid-STROBE -> cart_wr high 5 cycles; ack at edge 7.
- Reset pulse during STROBE of a write to 0xA000 -> cart_wr=0 and nCS=1 immediately; no ack; the next request behaves normally.
- Read 0x8000, then write 0xFF80 back-to-back with req held -> no cart_rd, cart_wr or nCS assertion; each acks after 4 edges; read rdata=0xFF; second request accepted on the first ack cycle.
